// File: rtl/number_entry_buffer.sv
// number_entry_buffer: keypad-side digit store for operand entry.
// Digits are shifted in at index 0 (least significant, most recent), removed by
// backspace or clear, and read back through a combinational scan port. A small
// converter FSM rebuilds the binary value after every accepted modification,
// one digit per clock, starting from the most significant stored digit.
//
// Command handshake: digit_valid / backspace / clear are single-cycle strobes
// sampled on the rising edge with no ready back-pressure; clear beats
// backspace beats digit_valid, and only the winner is acted on. value is
// meaningful only while value_valid=1 (busy is its complement).
module number_entry_buffer #(
  parameter int MAX_DIGITS = 8,
  parameter int IDX_W      = 3,
  parameter int BIN_W      = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       digit_in,
  input  logic             digit_valid,
  input  logic             backspace,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [3:0]       rd_digit,
  output logic [IDX_W-1:0] counter_total,
  output logic [IDX_W:0]   digit_count,
  output logic             full,
  output logic [BIN_W-1:0] value,
  output logic             value_valid,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  localparam logic [IDX_W:0] L_MAX = MAX_DIGITS[IDX_W:0];
  localparam logic [IDX_W:0] L_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [3:0]       r_slot [MAX_DIGITS];
  logic [IDX_W:0]   r_count;
  state_t           r_state;
  state_t           w_next_state;
  logic [BIN_W-1:0] r_acc;
  logic [IDX_W-1:0] r_ptr;
  logic [BIN_W-1:0] r_value;
  logic             r_valid;

  logic             w_full;
  logic             w_empty;
  logic [IDX_W:0]   w_cnt_m1;
  logic             w_do_clear;
  logic             w_do_bs;
  logic             w_do_app;
  logic             w_mod;
  logic [BIN_W-1:0] w_acc_next;

  assign w_full   = (r_count == L_MAX);
  assign w_empty  = (r_count == '0);
  assign w_cnt_m1 = r_count - L_ONE;

  // Command arbitration: a lower-priority strobe is dropped whenever a
  // higher-priority one is present, even if the higher one turns out a no-op.
  assign w_do_clear = clear;
  assign w_do_bs    = !clear && backspace && !w_empty;
  assign w_do_app   = !clear && !backspace && digit_valid &&
                      (digit_in <= 4'd9) && !w_full;
  assign w_mod      = w_do_clear || w_do_bs || w_do_app;

  // acc*10 + digit, built from shifts; 99,999,999 fits in BIN_W bits.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + BIN_W'(r_slot[r_ptr]);

  // Digit storage and count: shift up on append, shift down on backspace.
  always_ff @(posedge clk) begin
    if (rst || w_do_clear) begin
      for (int i = 0; i < MAX_DIGITS; i++) r_slot[i] <= 4'd0;
      r_count <= '0;
    end else if (w_do_bs) begin
      for (int i = 0; i < MAX_DIGITS - 1; i++) r_slot[i] <= r_slot[i+1];
      r_slot[MAX_DIGITS-1] <= 4'd0;
      r_count <= w_cnt_m1;
    end else if (w_do_app) begin
      for (int i = 1; i < MAX_DIGITS; i++) r_slot[i] <= r_slot[i-1];
      r_slot[0] <= digit_in;
      r_count <= r_count + L_ONE;
    end
  end

  // Converter state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Converter next state: any accepted edit restarts from LOAD.
  always_comb begin
    w_next_state = r_state;
    if (w_mod) begin
      w_next_state = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_IDLE;
        S_LOAD:  w_next_state = w_empty ? S_IDLE : S_ACC;
        S_ACC:   w_next_state = (r_ptr == '0) ? S_IDLE : S_ACC;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Converter datapath: walk from the top digit down to slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_ptr   <= '0;
      r_value <= '0;
      r_valid <= 1'b1;
    end else if (w_mod) begin
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_acc <= '0;
          r_ptr <= w_cnt_m1[IDX_W-1:0];
          if (w_empty) begin
            r_value <= '0;
            r_valid <= 1'b1;
          end
        end
        S_ACC: begin
          r_acc <= w_acc_next;
          r_ptr <= r_ptr - 1'b1;
          if (r_ptr == '0) begin
            r_value <= w_acc_next;
            r_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Scan read: indices beyond the stored digits read as zero.
  always_comb begin
    rd_digit = 4'd0;
    if ({1'b0, rd_idx} < r_count) rd_digit = r_slot[rd_idx];
  end

  assign counter_total = w_empty ? '0 : w_cnt_m1[IDX_W-1:0];
  assign digit_count   = r_count;
  assign full          = w_full;
  assign value         = r_value;
  assign value_valid   = r_valid;
  assign busy          = ~r_valid;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_number_entry_buffer.sv
// Bench for number_entry_buffer: directed entry sequences with hand-computed
// results. Each expected conversion result (value plus the cycle on which
// value_valid must rise) is queued by the driver; a negedge monitor pops one
// entry per rising value_valid and flags any rise nobody asked for.
module tb_number_entry_buffer;

  localparam int BIN_W = 27;
  localparam int IDX_W = 3;
  localparam int EW    = BIN_W + 32;

  logic             clk;
  logic             rst;
  logic [3:0]       digit_in;
  logic             digit_valid;
  logic             backspace;
  logic             clear;
  logic [IDX_W-1:0] rd_idx;
  logic [3:0]       rd_digit;
  logic [IDX_W-1:0] counter_total;
  logic [IDX_W:0]   digit_count;
  logic             full;
  logic [BIN_W-1:0] value;
  logic             value_valid;
  logic             busy;
  logic [1:0]       dbg_state;

  number_entry_buffer #(.MAX_DIGITS(8), .IDX_W(IDX_W), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .backspace(backspace), .clear(clear), .rd_idx(rd_idx), .rd_digit(rd_digit),
    .counter_total(counter_total), .digit_count(digit_count), .full(full),
    .value(value), .value_valid(value_valid), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int last_e   = 0;

  logic [EW-1:0] exp_q[$];
  logic          mon_en = 1'b0;
  logic          prev_v = 1'b1;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [BIN_W-1:0] v, input int c);
    exp_q.push_back({v, 32'(c)});
  endtask

  // Monitor: every rising value_valid must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (value_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_rise", {37'd0, value}, 64'hFFFF_FFFF);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("result_value", {37'd0, value}, {37'd0, e[EW-1:32]});
          chk("result_cycle", 64'(cyc), {32'd0, e[31:0]});
        end
      end
      prev_v = value_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds the strobes across exactly one rising edge.
  task automatic strobe(input logic c, input logic b, input logic v, input logic [3:0] d);
    clear = c; backspace = b; digit_valid = v; digit_in = d;
    @(negedge clk);
    clear = 1'b0; backspace = 1'b0; digit_valid = 1'b0;
    last_e = cyc;
  endtask

  task automatic append(input logic [3:0] d);
    strobe(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic read_chk(input logic [IDX_W-1:0] idx, input logic [3:0] exp, input string name);
    rd_idx = idx;
    #1;
    chk(name, {60'd0, rd_digit}, {60'd0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; digit_in = 4'd0; digit_valid = 1'b0; backspace = 1'b0;
    clear = 1'b0; rd_idx = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 64'(digit_count), 64'd0);
    chk("rst_total", 64'(counter_total), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_value", 64'(value), 64'd0);
    chk("rst_valid", 64'(value_valid), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    prev_v = 1'b1;
    mon_en = 1'b1;

    // 1,2,3 back to back: 123, valid 4 edges after the '3' strobe.
    append(4'd1); append(4'd2); append(4'd3);
    exp_push(27'd123, last_e + 4);
    chk("abc_count", 64'(digit_count), 64'd3);
    chk("abc_total", 64'(counter_total), 64'd2);
    chk("abc_busy", 64'(busy), 64'd1);
    read_chk(3'd0, 4'd3, "abc_rd0");
    read_chk(3'd1, 4'd2, "abc_rd1");
    read_chk(3'd2, 4'd1, "abc_rd2");
    read_chk(3'd5, 4'd0, "abc_rd5");
    wait_drain();

    // Fill with nines.
    strobe(1'b1, 1'b0, 1'b0, 4'd0);
    exp_push(27'd0, last_e + 1);
    wait_drain();
    for (int i = 0; i < 8; i++) append(4'd9);
    exp_push(27'd99999999, last_e + 9);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_total", 64'(counter_total), 64'd7);
    wait_drain();
    append(4'd5);
    chk("full_ignore_count", 64'(digit_count), 64'd8);
    chk("full_ignore_valid", 64'(value_valid), 64'd1);
    read_chk(3'd0, 4'd9, "full_ignore_rd0");
    wait_drain();
    chk("full_hold_value", 64'(value), 64'd99999999);

    // Backspace from full, then down to empty, then once more.
    strobe(1'b0, 1'b1, 1'b0, 4'd0);
    exp_push(27'd9999999, last_e + 8);
    chk("bs_count", 64'(digit_count), 64'd7);
    chk("bs_full", 64'(full), 64'd0);
    chk("bs_stale_value", 64'(value), 64'd99999999);
    read_chk(3'd7, 4'd0, "bs_rd7");
    wait_drain();
    for (int i = 0; i < 7; i++) strobe(1'b0, 1'b1, 1'b0, 4'd0);
    exp_push(27'd0, last_e + 1);
    wait_drain();
    strobe(1'b0, 1'b1, 1'b0, 4'd0);
    chk("bs_empty_count", 64'(digit_count), 64'd0);
    chk("bs_empty_valid", 64'(value_valid), 64'd1);
    wait_drain();
    chk("bs_empty_value", 64'(value), 64'd0);

    // "45", then non-BCD digits are ignored.
    append(4'd4); append(4'd5);
    exp_push(27'd45, last_e + 3);
    wait_drain();
    append(4'hA);
    chk("nonbcd_a_valid", 64'(value_valid), 64'd1);
    append(4'hF);
    chk("nonbcd_f_valid", 64'(value_valid), 64'd1);
    chk("nonbcd_count", 64'(digit_count), 64'd2);
    read_chk(3'd0, 4'd5, "nonbcd_rd0");
    wait_drain();

    // All three strobes together: clear wins.
    strobe(1'b1, 1'b1, 1'b1, 4'd7);
    exp_push(27'd0, last_e + 1);
    chk("combo_count", 64'(digit_count), 64'd0);
    read_chk(3'd0, 4'd0, "combo_rd0");
    wait_drain();

    // "1234" interrupted mid-ACC by a 7: single result 12347.
    append(4'd1); append(4'd2); append(4'd3); append(4'd4);
    repeat (2) @(negedge clk);
    chk("restart_midacc_busy", 64'(busy), 64'd1);
    append(4'd7);
    exp_push(27'd12347, last_e + 6);
    chk("restart_count", 64'(digit_count), 64'd5);
    wait_drain();

    // Reset during ACC of "56789".
    strobe(1'b1, 1'b0, 1'b0, 4'd0);
    exp_push(27'd0, last_e + 1);
    wait_drain();
    append(4'd5); append(4'd6); append(4'd7); append(4'd8); append(4'd9);
    repeat (3) @(negedge clk);
    exp_push(27'd0, cyc + 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_count", 64'(digit_count), 64'd0);
    chk("midrst_value", 64'(value), 64'd0);
    chk("midrst_valid", 64'(value_valid), 64'd1);
    chk("midrst_full", 64'(full), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'd0);
    read_chk(3'd0, 4'd0, "midrst_rd0");
    wait_drain();
    repeat (12) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/number_entry_buffer.md
Name: number_entry_buffer

Overview:
Write-side counterpart to the digit-scan number memory. Captures BCD digits entered one at a time from the keypad/input decoder, with backspace and clear. Exposes the same scan-read view the display path consumes: a digit at a scan index plus a highest-index count. Runs a sequential BCD-to-binary converter so the ALU always has the entered operand in binary.

Parameters:
MAX_DIGITS, 8, digit storage depth; also the maximum entry length.
IDX_W, 3, scan index width (log2 MAX_DIGITS).
BIN_W, 27, binary value width (holds 99,999,999).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
digit_in  in  4  BCD digit to append.
digit_valid  in  1  single-cycle strobe; append digit_in.
backspace  in  1  single-cycle strobe; remove the most recent digit.
clear  in  1  single-cycle strobe; empty the buffer.
rd_idx  in  IDX_W  scan index; 0 is the least-significant (most recent) digit.
rd_digit  out  4  digit at rd_idx; combinational.
counter_total  out  IDX_W  highest valid scan index (digit_count-1); 0 when empty.
digit_count  out  IDX_W+1  number of stored digits, 0..MAX_DIGITS.
full  out  1  digit_count == MAX_DIGITS.
value  out  BIN_W  binary value of the stored number.
value_valid  out  1  value matches the current buffer contents.
busy  out  1  conversion in progress (equals ~value_valid).

Behaviour:
- Reset (rst=1 at an edge): all digit slots 0, digit_count 0, counter_total 0, full 0, value 0, value_valid 1, busy 0, FSM in IDLE. Reset overrides every other input and aborts any conversion in progress.
- Command priority when several strobes are high in the same cycle: clear > backspace > digit_valid. Only the highest-priority command is acted on.
- Append: accepted only if digit_in <= 9 and full=0. All slots shift up one index, slot 0 takes digit_in, and digit_count increments. Non-BCD digits (0xA-0xF) and appends when full are ignored: no state change and no conversion restart.
- Backspace: accepted if digit_count > 0. Slots shift down one index, the top slot is zero-filled, and digit_count decrements. Backspace when empty is a no-op.
- Clear: all slots zeroed and digit_count set to 0. Always treated as an accepted modification, even when already empty.
- Read path: rd_digit = slot[rd_idx] if rd_idx < digit_count, else 0. There is no read latency.
- The counter_total and full outputs update on the same edge as digit_count.
- Converter FSM has three states: IDLE, LOAD, ACC.
  - Any accepted modification at edge E0 gives busy=1 and value_valid=0 after E0, and the FSM enters LOAD. This applies in every state: a modification during LOAD or ACC restarts the conversion in LOAD, and the partial result is discarded.
  - LOAD (one edge): acc=0 and ptr=digit_count-1. If digit_count==0, the next state is IDLE with value=0 and value_valid=1. Otherwise the next state is ACC.
  - ACC: acc = acc*10 + slot[ptr], computed as (acc<<3)+(acc<<1)+digit in BIN_W bits with no overflow possible. Then ptr decrements.
  - On the ACC edge where ptr==0: value takes the final acc, value_valid=1, and the next state is IDLE.
  - Latency: value_valid rises after edge E0+digit_count+1 (this covers digit_count=0 as well).
- value holds its last result while busy; the stale value is visible but flagged invalid. It changes only when a conversion completes or on reset.

Test Plan:
- Reset, then append 1,2,3 on consecutive cycles → digit_count 3, counter_total 2, rd_idx 0/1/2 reads 3/2/1, rd_idx 5 reads 0; value 123 with value_valid=1 exactly 4 edges after the '3' strobe.
- Append 9 eight times → full=1, value 99999999. A ninth append of 5 is ignored: digit_count stays 8, value_valid stays 1.
- From 99999999, backspace → digit_count 7, value 9999999 after 8 edges. Backspace 7 more times, then once on empty → count 0, value 0, no hang.
- Append 4'hA and 4'hF → no change, and value_valid never drops.
- Assert clear+backspace+digit_valid(7) together on buffer "45" → buffer empty, value 0 after 1 edge. Append 7 while the conversion of "1234" is mid-ACC → restart, final value 12347 with no intermediate value_valid pulse.
- Assert rst during ACC of "56789" → next cycle all outputs are at reset values (value 0, value_valid 1, count 0).
